// File: rtl/mod_tx_commut.sv
// Wide-to-narrow transmit commutator: splits IN_WIDTH-bit words into OUT_WIDTH-bit beats,
// LSB slice first, with a one-word holding buffer so back-to-back words stream without gaps.
module mod_tx_commut #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_bus,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 ready
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nx;
  logic [IN_WIDTH-1:0]   sh, sh_nx;
  logic [IN_WIDTH-1:0]   hold, hold_nx;
  logic                  hold_vld, hold_vld_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  ready_nx;
  logic                  accept, take, at_last;

  // in_ready depends only on registered state, so the sink cannot form a comb loop through us.
  assign in_ready  = !hold_vld;
  assign out_valid = (state == SEND);
  assign at_last   = (cnt == LAST);
  assign out_last  = out_valid && at_last;
  assign out_bus   = sh[OUT_WIDTH-1:0];
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      cnt      <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nx;
      sh       <= sh_nx;
      hold     <= hold_nx;
      hold_vld <= hold_vld_nx;
      cnt      <= cnt_nx;
      ready    <= ready_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sh_nx       = sh;
    hold_nx     = hold;
    hold_vld_nx = hold_vld;
    cnt_nx      = cnt;
    ready_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_nx    = in_bus;
          cnt_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (take && at_last) begin
          ready_nx = 1'b1;
          cnt_nx   = '0;
          // A full hold blocks accept, so draining it never races a new word.
          if (hold_vld) begin
            sh_nx       = hold;
            hold_vld_nx = 1'b0;
          end else if (accept) begin
            sh_nx = in_bus;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (take) begin
            sh_nx  = sh >> OUT_WIDTH;
            cnt_nx = cnt + 1'b1;
          end
          if (accept) begin
            hold_nx     = in_bus;
            hold_vld_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_tx_commut.sv
// Self-checking bench for mod_tx_commut: a queue-of-words reference model predicts every
// output each cycle under directed and randomized traffic; a 16/8 instance covers loopback.
module tb_mod_tx_commut;

  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_bus;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_bus;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        ready;

  logic [15:0] n_in_bus;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [7:0]  n_out_bus;
  logic        n_out_valid;
  logic        n_out_ready;
  logic        n_out_last;
  logic        n_ready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  int          idx = 0;
  logic        ready_exp = 1'b0;
  logic        skip_check = 1'b1;
  logic        ordy_g = 1'b1;
  logic [15:0] rebuilt;

  always #5 clk = ~clk;

  mod_tx_commut #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ready(ready)
  );

  mod_tx_commut #(.IN_WIDTH(16), .OUT_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst), .in_bus(n_in_bus), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .out_bus(n_out_bus), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_last(n_out_last), .ready(n_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model view: q holds words accepted but not fully sent; q[0] is on the wire at beat idx.
  task automatic check_output();
    logic [31:0] w;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("ready", ready, ready_exp);
    if (q.size() > 0) begin
      w = q[0];
      chk("out_bus", out_bus, w[idx*8 +: 8]);
      chk("out_last", out_last, idx == BEATS - 1);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic iv, input logic [31:0] w,
                                input logic ordy);
    logic take, acc;
    if (!skip_check) check_output();
    rst       = r;
    in_valid  = iv;
    in_bus    = w;
    out_ready = ordy;
    take = (q.size() > 0) && ordy;
    acc  = iv && (q.size() < 2);
    if (r) begin
      q.delete();
      idx       = 0;
      ready_exp = 1'b0;
    end else begin
      ready_exp = take && (idx == BEATS - 1);
      if (take) begin
        if (idx == BEATS - 1) begin
          void'(q.pop_front());
          idx = 0;
        end else begin
          idx++;
        end
      end
      if (acc) q.push_back(w);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    while (q.size() >= 2 && n < 50) begin
      apply_stimulus(1'b0, 1'b1, w, ordy_g);
      n++;
    end
    if (n >= 50) begin
      failures++;
      $error("[TB] FAIL send_timeout observed=%0d expected<50", n);
    end
    apply_stimulus(1'b0, 1'b1, w, ordy_g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, $urandom, ordy_g);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0;
    n_in_bus = '0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
    skip_check = 1'b0;

    $display("[TB] reset mid-transfer");
    ordy_g = 1'b1;
    send_word(32'hDEADBEEF);
    send_word(32'h11223344);
    idle(1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
    idle(3);

    $display("[TB] single word");
    send_word(32'hA1B2C3D4);
    idle(6);

    $display("[TB] back-to-back");
    send_word(32'h03020100);
    send_word(32'h07060504);
    idle(10);

    $display("[TB] backpressure");
    send_word(32'h44332211);
    idle(2);
    ordy_g = 1'b0;
    idle(3);
    ordy_g = 1'b1;
    idle(6);

    $display("[TB] hold full");
    ordy_g = 1'b0;
    send_word(32'hAAAA0001);
    send_word(32'hBBBB0002);
    ordy_g = 1'b1;
    send_word(32'hCCCC0003);
    idle(14);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, ($urandom % 4) != 0);
    ordy_g = 1'b1;
    idle(12);

    $display("[TB] 16/8 loopback");
    in_valid = 1'b0;
    n_in_bus = 16'hBEEF; n_in_valid = 1'b1; n_out_ready = 1'b1;
    chk("n_in_ready", n_in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    n_in_valid = 1'b0; n_in_bus = 16'h0000;
    chk("n_valid0", n_out_valid, 1'b1);
    chk("n_beat0", n_out_bus, 8'hEF);
    chk("n_last0", n_out_last, 1'b0);
    rebuilt[7:0] = n_out_bus;
    @(posedge clk); @(negedge clk);
    chk("n_beat1", n_out_bus, 8'hBE);
    chk("n_last1", n_out_last, 1'b1);
    rebuilt[15:8] = n_out_bus;
    @(posedge clk); @(negedge clk);
    chk("n_ready", n_ready, 1'b1);
    chk("n_valid_end", n_out_valid, 1'b0);
    chk("n_rebuilt", rebuilt, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
